id_ex_control_stage: RTL and testbench

ID/EX pipeline stage for the control path of the pipelined RISC-V core. It sits directly downstream of the opcode decoder, registering its control outputs and register-field indices into the EX stage. It also detects load-use hazards, throttling fetch and injecting bubbles. A branch-taken flush from later stages kills the instruction currently in ID.

---
 rtl/id_ex_control_stage_if.sv | 48 ++++
 rtl/id_ex_control_stage.sv | 88 ++++++++
 tb/tb_id_ex_control_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_control_stage_if.sv
// ID/EX control-stage bundle: decoder control and register fields flowing in,
// registered EX control plus hazard throttling flowing back out.
interface id_ex_control_stage_if;
  logic        Branch;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        flush;

  logic        ex_Branch;
  logic        ex_MemRead;
  logic        ex_MemtoReg;
  logic        ex_MemWrite;
  logic        ex_ALUSrc;
  logic        ex_RegWrite;
  logic [1:0]  ex_ALUOp;
  logic        ex_valid;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic [15:0] bubble_count;

  modport master (
    output Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
    output id_valid, id_rs1, id_rs2, id_rd, flush,
    input  ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
    input  ex_ALUOp, ex_valid, ex_rs1, ex_rs2, ex_rd,
    input  stall, PCWrite, IF_ID_Write, bubble_count
  );

  modport slave (
    input  Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
    input  id_valid, id_rs1, id_rs2, id_rd, flush,
    output ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
    output ex_ALUOp, ex_valid, ex_rs1, ex_rs2, ex_rd,
    output stall, PCWrite, IF_ID_Write, bubble_count
  );
endinterface

// File: rtl/id_ex_control_stage.sv
// ID/EX control pipeline register with load-use hazard detection, bubble
// injection on stall or branch flush, and a saturating bubble counter.
module id_ex_control_stage (
  input logic                  clk,
  input logic                  reset,
  id_ex_control_stage_if.slave bus
);

  typedef struct packed {
    logic       branch;
    logic       memRead;
    logic       memtoReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [1:0] aluOp;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_slot_t;

  ex_slot_t    exSlot;
  ex_slot_t    idSlot;
  ex_slot_t    nextSlot;
  logic [15:0] bubbleCnt;
  logic        hazard;
  logic        stallInt;
  logic        bubble;

  assign idSlot = '{
    branch:   bus.Branch,
    memRead:  bus.MemRead,
    memtoReg: bus.MemtoReg,
    memWrite: bus.MemWrite,
    aluSrc:   bus.ALUSrc,
    regWrite: bus.RegWrite,
    aluOp:    bus.ALUOp,
    valid:    bus.id_valid,
    rs1:      bus.id_rs1,
    rs2:      bus.id_rs2,
    rd:       bus.id_rd
  };

  // Both source fields are compared unconditionally; stalls on formats without
  // rs2 are intentionally conservative.
  assign hazard = exSlot.valid & exSlot.memRead & (exSlot.rd != 5'd0) & bus.id_valid &
                  ((exSlot.rd == bus.id_rs1) | (exSlot.rd == bus.id_rs2));

  assign stallInt = hazard & ~bus.flush;
  assign bubble   = bus.flush | stallInt;

  always_comb begin
    nextSlot = idSlot;
    if (bubble) begin
      nextSlot = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exSlot    <= '0;
      bubbleCnt <= 16'd0;
    end else begin
      exSlot <= nextSlot;
      if (bubble && (bubbleCnt != 16'hFFFF)) begin
        bubbleCnt <= bubbleCnt + 16'd1;
      end
    end
  end

  assign bus.ex_Branch    = exSlot.branch;
  assign bus.ex_MemRead   = exSlot.memRead;
  assign bus.ex_MemtoReg  = exSlot.memtoReg;
  assign bus.ex_MemWrite  = exSlot.memWrite;
  assign bus.ex_ALUSrc    = exSlot.aluSrc;
  assign bus.ex_RegWrite  = exSlot.regWrite;
  assign bus.ex_ALUOp     = exSlot.aluOp;
  assign bus.ex_valid     = exSlot.valid;
  assign bus.ex_rs1       = exSlot.rs1;
  assign bus.ex_rs2       = exSlot.rs2;
  assign bus.ex_rd        = exSlot.rd;
  assign bus.stall        = stallInt;
  assign bus.PCWrite      = ~stallInt;
  assign bus.IF_ID_Write  = ~stallInt;
  assign bus.bubble_count = bubbleCnt;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Self-checking bench for id_ex_control_stage: directed vector table, reset and
// saturation sequences, and randomized traffic against an instruction-level model.
module tb_id_ex_control_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_control_stage_if bus ();

  id_ex_control_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       branch;
    logic       memRead;
    logic       memtoReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [1:0] aluOp;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       flush;
  } idIn_t;

  typedef struct {
    idIn_t       in;
    logic        expStall;
    logic        expValid;
    logic [4:0]  expRd;
    logic [15:0] expCount;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  idIn_t mEx;
  int    mCount;
  vec_t  vecs[$];

  function automatic idIn_t mkIn(logic v, logic ld, logic wr, logic st, logic [1:0] op,
                                 logic [4:0] s1, logic [4:0] s2, logic [4:0] d, logic fl);
    idIn_t r;
    r.branch = 1'b0;   r.memRead = ld;  r.memtoReg = ld;       r.memWrite = st;
    r.aluSrc = ld | st; r.regWrite = wr; r.aluOp = op;         r.valid = v;
    r.rs1 = s1;         r.rs2 = s2;      r.rd = d;             r.flush = fl;
    return r;
  endfunction

  function automatic vec_t mkVec(idIn_t r, logic s, logic v, logic [4:0] d, logic [15:0] c);
    vec_t x;
    x.in = r; x.expStall = s; x.expValid = v; x.expRd = d; x.expCount = c;
    return x;
  endfunction

  function automatic logic [23:0] packSlot(idIn_t r);
    return {r.branch, r.memRead, r.memtoReg, r.memWrite, r.aluSrc, r.regWrite,
            r.aluOp, r.valid, r.rs1, r.rs2, r.rd};
  endfunction

  function automatic logic [23:0] observedSlot();
    return {bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg, bus.ex_MemWrite, bus.ex_ALUSrc,
            bus.ex_RegWrite, bus.ex_ALUOp, bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd};
  endfunction

  // Load in EX whose destination is read by a valid ID instruction.
  function automatic bit modelHazard(idIn_t r);
    return mEx.valid && mEx.memRead && (mEx.rd != 0) && r.valid &&
           ((mEx.rd == r.rs1) || (mEx.rd == r.rs2));
  endfunction

  function automatic void modelReset();
    mEx    = '{default: '0};
    mCount = 0;
  endfunction

  function automatic void modelEdge(idIn_t r);
    if (r.flush || modelHazard(r)) begin
      mEx = '{default: '0};
      if (mCount < 65535) mCount = mCount + 1;
    end else begin
      mEx = r;
    end
  endfunction

  task automatic applyStimulus(input idIn_t r);
    bus.Branch   = r.branch;   bus.MemRead = r.memRead; bus.MemtoReg = r.memtoReg;
    bus.MemWrite = r.memWrite; bus.ALUSrc  = r.aluSrc;  bus.RegWrite = r.regWrite;
    bus.ALUOp    = r.aluOp;    bus.id_valid = r.valid;  bus.id_rs1   = r.rs1;
    bus.id_rs2   = r.rs2;      bus.id_rd    = r.rd;     bus.flush    = r.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic checkComb(input string name, input logic expStall);
    checkOutput({name, " stall/PCWrite/IF_ID_Write"},
                {29'd0, bus.stall, bus.PCWrite, bus.IF_ID_Write},
                {29'd0, expStall, ~expStall, ~expStall});
  endtask

  task automatic checkEx(input string name);
    checkOutput({name, " ex slot"}, {8'd0, observedSlot()}, {8'd0, packSlot(mEx)});
    checkOutput({name, " bubble_count"}, {16'd0, bus.bubble_count}, mCount);
  endtask

  // One full cycle: drive at negedge, check combinational outputs, clock, check registers.
  task automatic runCycle(input idIn_t r, input string name, output logic sawStall);
    logic expStall;
    @(negedge clk);
    applyStimulus(r);
    #1;
    expStall = modelHazard(r) && !r.flush;
    sawStall = bus.stall;
    checkComb(name, expStall);
    @(posedge clk);
    modelEdge(r);
    #1;
    checkEx(name);
  endtask

  initial begin
    idIn_t r;
    idIn_t prev;
    logic  s;
    logic  lastStall;

    reset = 1'b0;
    applyStimulus(mkIn(0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkEx("reset state");
    checkComb("reset state", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mkVec(mkIn(1, 0, 1, 0, 2'b10, 1, 2, 5, 0), 0, 1, 5, 0));
    vecs.push_back(mkVec(mkIn(1, 1, 1, 0, 2'b00, 2, 0, 7, 0), 0, 1, 7, 0));
    vecs.push_back(mkVec(mkIn(1, 0, 1, 0, 2'b10, 7, 3, 8, 0), 1, 0, 0, 1));
    vecs.push_back(mkVec(mkIn(1, 0, 1, 0, 2'b10, 7, 3, 8, 0), 0, 1, 8, 1));
    vecs.push_back(mkVec(mkIn(1, 1, 1, 0, 2'b00, 4, 0, 0, 0), 0, 1, 0, 1));
    vecs.push_back(mkVec(mkIn(1, 0, 1, 0, 2'b10, 9, 0, 10, 0), 0, 1, 10, 1));
    vecs.push_back(mkVec(mkIn(1, 1, 1, 0, 2'b00, 1, 0, 3, 0), 0, 1, 3, 1));
    vecs.push_back(mkVec(mkIn(1, 0, 1, 0, 2'b10, 3, 5, 11, 1), 0, 0, 0, 2));
    vecs.push_back(mkVec(mkIn(0, 0, 0, 0, 2'b00, 0, 0, 12, 0), 0, 0, 12, 2));
    vecs.push_back(mkVec(mkIn(1, 1, 1, 0, 2'b00, 2, 0, 6, 0), 0, 1, 6, 2));
    vecs.push_back(mkVec(mkIn(0, 0, 1, 0, 2'b10, 6, 0, 4, 0), 0, 0, 4, 2));
    vecs.push_back(mkVec(mkIn(1, 1, 1, 0, 2'b00, 1, 0, 9, 0), 0, 1, 9, 2));
    vecs.push_back(mkVec(mkIn(1, 0, 0, 1, 2'b00, 1, 9, 0, 0), 1, 0, 0, 3));
    vecs.push_back(mkVec(mkIn(1, 0, 0, 1, 2'b00, 1, 9, 0, 0), 0, 1, 0, 3));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      runCycle(vecs[i].in, tag, s);
      checkOutput({tag, " table stall"}, {31'd0, s}, {31'd0, vecs[i].expStall});
      checkOutput({tag, " table ex_valid/ex_rd/count"},
                  {10'd0, bus.ex_valid, bus.ex_rd, bus.bubble_count},
                  {10'd0, vecs[i].expValid, vecs[i].expRd, vecs[i].expCount});
    end

    // Asynchronous reset in the middle of a load-use stall.
    runCycle(mkIn(1, 1, 1, 0, 2'b00, 1, 0, 3, 0), "pre-reset load", s);
    @(negedge clk);
    applyStimulus(mkIn(1, 0, 1, 0, 2'b10, 3, 4, 13, 0));
    #1;
    checkComb("stall before reset", 1'b1);
    #1;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset ex/count", {observedSlot(), bus.bubble_count}, 40'd0);
    checkComb("async reset", 1'b0);
    @(posedge clk);
    #1;
    checkEx("held in reset");
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic; a stalled instruction is re-presented like a held IF/ID.
    lastStall = 1'b0;
    prev = mkIn(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (lastStall) begin
        r = prev;
      end else begin
        r.valid    = ($urandom_range(3) != 0);
        r.branch   = $urandom_range(1);
        r.memRead  = $urandom_range(1);
        r.memtoReg = $urandom_range(1);
        r.memWrite = $urandom_range(1);
        r.aluSrc   = $urandom_range(1);
        r.regWrite = $urandom_range(1);
        r.aluOp    = 2'($urandom_range(3));
        r.rs1      = 5'($urandom_range(7));
        r.rs2      = 5'($urandom_range(7));
        r.rd       = 5'($urandom_range(7));
        r.flush    = r.valid && ($urandom_range(7) == 0);
      end
      prev = r;
      runCycle(r, "random", lastStall);
    end

    // Saturation: continuous flush must stop at 16'hFFFF.
    @(negedge clk);
    reset = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    r = mkIn(1, 0, 1, 0, 2'b10, 1, 2, 3, 1);
    applyStimulus(r);
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      modelEdge(r);
      #1;
      if (n == 65534) checkOutput("sat count 65534", {16'd0, bus.bubble_count}, 32'd65534);
      if (n == 65535) checkOutput("sat count 65535", {16'd0, bus.bubble_count}, 32'hFFFF);
      if (n == 65540) begin
        checkOutput("sat count held", {16'd0, bus.bubble_count}, 32'hFFFF);
        checkEx("sat model");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
